// File: rtl/fa_nbit_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit carry chunk per stage with
// a registered carry between stages and a single global valid/ready stall.
module fa_nbit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // acc holds finished sum chunks below the stage and raw A chunks above it
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  bx_d  [STAGES];
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] am_q, am_d;
  logic [STAGES-1:0] bm_q, bm_d;
  logic              ovf_q, ovf_d;

  logic             adv;
  logic [WIDTH-1:0] bx_in;
  logic             cin;
  logic [WIDTH-1:0] src_a, src_b;
  logic             src_c, src_v, src_am, src_bm;
  logic [CW:0]      chunk;

  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
  endfunction

  assign adv       = !vld_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign s         = acc_q[LAST];
  assign co        = cy_q[LAST];
  assign ovf       = ovf_q;

  always_comb begin
    bx_in  = sub ? ~b : b;
    cin    = sub ? 1'b1 : ci;
    src_a  = '0;
    src_b  = '0;
    src_c  = 1'b0;
    src_v  = 1'b0;
    src_am = 1'b0;
    src_bm = 1'b0;
    chunk  = '0;
    vld_d  = '0;
    cy_d   = '0;
    am_d   = '0;
    bm_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      // stage boundary: stage k consumes the register of stage k-1
      if (k == 0) begin
        src_a  = a;
        src_b  = bx_in;
        src_c  = cin;
        src_v  = in_valid;
        src_am = a[WIDTH-1];
        src_bm = bx_in[WIDTH-1];
      end else begin
        src_a  = acc_q[k-1];
        src_b  = bx_q[k-1];
        src_c  = cy_q[k-1];
        src_v  = vld_q[k-1];
        src_am = am_q[k-1];
        src_bm = bm_q[k-1];
      end
      chunk                  = add_chunk(src_a[k*CW +: CW], src_b[k*CW +: CW], src_c);
      acc_d[k]               = src_a;
      acc_d[k][k*CW +: CW]   = chunk[CW-1:0];
      bx_d[k]                = src_b;
      cy_d[k]                = chunk[CW];
      vld_d[k]               = src_v;
      am_d[k]                = src_am;
      bm_d[k]                = src_bm;
    end
    ovf_d = (am_d[LAST] == bm_d[LAST]) && (acc_d[LAST][WIDTH-1] != am_d[LAST]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        bx_q[k]  <= '0;
      end
      vld_q <= '0;
      cy_q  <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        bx_q[k]  <= bx_d[k];
      end
      vld_q <= vld_d;
      cy_q  <= cy_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fa_nbit_pipe.sv
// Scoreboard bench for fa_nbit_pipe: directed checks on the 8-bit/2-stage
// build plus a random sweep over three other parameter sets.
`timescale 1ns/1ps
module tb_fa_nbit_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main 8-bit / 2-stage instance
  logic       in_valid = 1'b0, in_ready, ci = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0, s;
  logic       out_valid, out_ready = 1'b1, co, ovf;
  logic [9:0] q_main [$];

  fa_nbit_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .co(co), .ovf(ovf));

  // sweep instances share stimulus, each with its own in_valid
  logic [31:0] sa = '0, sb = '0;
  logic        sci = 1'b0, ssub = 1'b0, sr = 1'b1;
  logic        iv16 = 1'b0, iv8 = 1'b0, iv32 = 1'b0;
  logic        rdy16, rdy8, rdy32, ov16, ov8, ov32;
  logic        c16, c8, c32, o16, o8, o32;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] s32;

  fa_nbit_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
    .a(sa[15:0]), .b(sb[15:0]), .ci(sci), .sub(ssub), .out_valid(ov16),
    .out_ready(sr), .s(s16), .co(c16), .ovf(o16));
  fa_nbit_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
    .a(sa[7:0]), .b(sb[7:0]), .ci(sci), .sub(ssub), .out_valid(ov8),
    .out_ready(sr), .s(s8), .co(c8), .ovf(o8));
  fa_nbit_pipe #(.WIDTH(32), .STAGES(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32),
    .a(sa), .b(sb), .ci(sci), .sub(ssub), .out_valid(ov32),
    .out_ready(sr), .s(s32), .co(c32), .ovf(o32));

  // behavioural reference: returns {ovf, co, s zero-extended to 32 bits}
  function automatic logic [33:0] model(input int w, input logic [31:0] x, y,
                                        input logic c, input logic sb_m);
    logic [32:0] m, bx, sum;
    logic [31:0] r;
    logic        cin, ov;
    m   = (33'd1 << w) - 33'd1;
    bx  = (sb_m ? {1'b0, ~y} : {1'b0, y}) & m;
    cin = sb_m ? 1'b1 : c;
    sum = ({1'b0, x} & m) + bx + {32'd0, cin};
    r   = sum[31:0] & m[31:0];
    ov  = (x[w-1] == bx[w-1]) && (r[w-1] != x[w-1]);
    return {ov, sum[w], r};
  endfunction

  // one cycle on the main instance: drive at negedge, sample 1ns later
  task automatic drive_cycle(input bit iv, input logic [7:0] ia, ib,
                             input logic ici, isub, ordy, input logic [9:0] exp_in,
                             output bit acc, output bit pop,
                             output logic [9:0] act, output logic [9:0] exp);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    act = {ovf, co, s};
    exp = 'x;
    if (pop && q_main.size() > 0) exp = q_main.pop_front();
    if (acc) q_main.push_back(exp_in);
  endtask

  task automatic test_reset;
    bit acc, pop;
    logic [9:0] act, exp;
    drive_cycle(1'b1, 8'h33, 8'h11, 1'b0, 1'b0, 1'b0, 10'h044, acc, pop, act, exp);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, acc, pop, act, exp);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, acc, pop, act, exp);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_pre out_valid got=%b want=1", out_valid); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (s !== 8'h00) begin bad++; $display("FAIL reset_s got=%h want=00", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL reset_co got=%b want=0", co); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    q_main.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_latency;
    bit acc, pop;
    logic [9:0] act, exp;
    int hit;
    hit = -1;
    drive_cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 10'h100, acc, pop, act, exp);
    for (int j = 1; j <= 6; j++) begin
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, acc, pop, act, exp);
      if (pop && hit < 0) begin
        hit = j;
        total++;
        if (act !== exp) begin bad++; $display("FAIL latency_value got=%h want=%h", act, exp); end
      end
    end
    total++;
    if (hit != 2) begin bad++; $display("FAIL latency_edges got=%0d want=2", hit); end
  endtask

  task automatic test_add;
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h0F};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] te [3] = '{10'h100, 10'h280, 10'h010};
    bit acc, pop;
    logic [9:0] act, exp;
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) drive_cycle(1'b1, ta[i], tb[i], tc[i], 1'b0, 1'b1, te[i], acc, pop, act, exp);
      else       drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, acc, pop, act, exp);
      if (pop) begin
        n++; total++;
        if (act !== exp) begin bad++; $display("FAIL add_beat%0d got=%h want=%h", n, act, exp); end
      end
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL add_count got=%0d want=3", n); end
  endtask

  task automatic test_sub;
    logic [7:0] ta [3] = '{8'h05, 8'h80, 8'h07};
    logic [7:0] tb [3] = '{8'h07, 8'h01, 8'h07};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] te [3] = '{10'h0FE, 10'h37F, 10'h100};
    bit acc, pop;
    logic [9:0] act, exp;
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) drive_cycle(1'b1, ta[i], tb[i], tc[i], 1'b1, 1'b1, te[i], acc, pop, act, exp);
      else       drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, acc, pop, act, exp);
      if (pop) begin
        n++; total++;
        if (act !== exp) begin bad++; $display("FAIL sub_beat%0d got=%h want=%h", n, act, exp); end
      end
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL sub_count got=%0d want=3", n); end
  endtask

  task automatic test_back_to_back;
    bit acc, pop, ordy;
    logic [9:0] act, exp;
    int idx, n;
    idx = 0; n = 0;
    for (int c = 0; c < 16; c++) begin
      ordy = !(c >= 2 && c <= 4);
      if (idx < 4)
        drive_cycle(1'b1, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, ordy,
                    10'(2 * (idx + 1)), acc, pop, act, exp);
      else
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, 10'h000, acc, pop, act, exp);
      if (acc) idx++;
      if (!ordy) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
        total++;
        if ({out_valid, s} !== 9'h102) begin bad++; $display("FAIL stall_hold c=%0d got=%h want=102", c, {out_valid, s}); end
      end
      if (pop) begin
        n++; total++;
        if (act !== exp) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", n, act, exp); end
      end
    end
    total++;
    if (n != 4 || q_main.size() != 0) begin
      bad++; $display("FAIL b2b_count got=%0d want=4 left=%0d", n, q_main.size());
    end
  endtask

  task automatic test_reset_mid_stream;
    bit acc, pop;
    logic [9:0] act, exp;
    int n;
    n = 0;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 8'(8'h40 + i), 8'h01, 1'b0, 1'b0, 1'b0, 10'h3FF, acc, pop, act, exp);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    q_main.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 10'h030, acc, pop, act, exp);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, acc, pop, act, exp);
      if (pop) begin
        n++; total++;
        if (act !== exp) begin bad++; $display("FAIL rstmid_beat%0d got=%h want=%h", n, act, exp); end
      end
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", n); end
  endtask

  task automatic test_sweep;
    logic [33:0] q16 [$], q8 [$], q32 [$];
    int          t16 [$], t8 [$], t32 [$];
    int na16, na8, na32, np16, np8, np32, tt;
    logic [33:0] exp;
    bit ph;
    na16 = 0; na8 = 0; na32 = 0; np16 = 0; np8 = 0; np32 = 0;
    for (int c = 0; c < 20000; c++) begin
      if (np16 >= 1000 && np8 >= 1000 && np32 >= 1000) break;
      @(negedge clk);
      ph   = (c >= 60);
      sr   = ph ? ($urandom_range(0, 3) != 0) : 1'b1;
      sa   = $urandom; sb = $urandom;
      sci  = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1));
      iv16 = ($urandom_range(0, 3) != 0) && (na16 < 1000);
      iv8  = ($urandom_range(0, 3) != 0) && (na8 < 1000);
      iv32 = ($urandom_range(0, 3) != 0) && (na32 < 1000);
      if (na16 >= 1000 && na8 >= 1000 && na32 >= 1000) sr = 1'b1;
      #1;
      if (ov16 && sr) begin
        exp = 'x; tt = -1;
        if (q16.size() > 0) begin exp = q16.pop_front(); tt = t16.pop_front(); end
        np16++; total++;
        if ({o16, c16, 16'h0, s16} !== exp) begin bad++; $display("FAIL w16_beat%0d got=%h want=%h", np16, {o16, c16, 16'h0, s16}, exp); end
        if (!ph) begin
          total++;
          if (cyc + 1 - tt != 4) begin bad++; $display("FAIL w16_latency got=%0d want=4", cyc + 1 - tt); end
        end
      end
      if (ov8 && sr) begin
        exp = 'x; tt = -1;
        if (q8.size() > 0) begin exp = q8.pop_front(); tt = t8.pop_front(); end
        np8++; total++;
        if ({o8, c8, 24'h0, s8} !== exp) begin bad++; $display("FAIL w8_beat%0d got=%h want=%h", np8, {o8, c8, 24'h0, s8}, exp); end
        if (!ph) begin
          total++;
          if (cyc + 1 - tt != 1) begin bad++; $display("FAIL w8_latency got=%0d want=1", cyc + 1 - tt); end
        end
      end
      if (ov32 && sr) begin
        exp = 'x; tt = -1;
        if (q32.size() > 0) begin exp = q32.pop_front(); tt = t32.pop_front(); end
        np32++; total++;
        if ({o32, c32, s32} !== exp) begin bad++; $display("FAIL w32_beat%0d got=%h want=%h", np32, {o32, c32, s32}, exp); end
        if (!ph) begin
          total++;
          if (cyc + 1 - tt != 8) begin bad++; $display("FAIL w32_latency got=%0d want=8", cyc + 1 - tt); end
        end
      end
      if (iv16 && rdy16) begin q16.push_back(model(16, sa, sb, sci, ssub)); t16.push_back(cyc + 1); na16++; end
      if (iv8 && rdy8)   begin q8.push_back(model(8, sa, sb, sci, ssub));   t8.push_back(cyc + 1);  na8++;  end
      if (iv32 && rdy32) begin q32.push_back(model(32, sa, sb, sci, ssub)); t32.push_back(cyc + 1); na32++; end
    end
    @(negedge clk);
    iv16 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    total++;
    if (np16 != 1000 || np8 != 1000 || np32 != 1000) begin
      bad++; $display("FAIL sweep_count got=%0d/%0d/%0d want=1000 each", np16, np8, np32);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_stream();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
